// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared constants and requester ids for the sprite ROM arbiter
package rom_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int AW_DEF      = 17;
  localparam int DW_DEF      = 12;
  localparam int ROM_LAT_DEF = 2;

  typedef enum int {
    REQ_BACKGROUND = 0,
    REQ_HECATIA    = 1,
    REQ_MOON       = 2,
    REQ_PLAYER     = 3
  } req_id_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// rtl/rom_arbiter_rr_pick.sv - combinational round-robin pick starting at pointer p
module rr_pick
  import rom_arbiter_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] p,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin ROM read arbiter with fixed-latency tagged return path
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic                busy
);

  localparam int PW    = idx_w(N_REQ);
  localparam int DEPTH = 1 + ROM_LAT;

  logic [PW-1:0]    p;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic [N_REQ-1:0] tag_q [DEPTH];
  logic [DW-1:0]    rdata_q;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .p   (p),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign gnt = (rst || !en) ? '0 : pick_gnt;

  // The one-hot tag itself is the valid bit; stage DEPTH-1 lines up with rom_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rdata_q  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else begin
      rom_en   <= |gnt;
      tag_q[0] <= gnt;
      for (int k = 1; k < DEPTH; k++) tag_q[k] <= tag_q[k-1];
      if (|gnt) begin
        rom_addr <= addr[int'(pick_idx)*AW +: AW];
        p        <= (pick_idx == PW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      if (|tag_q[DEPTH-1]) rdata_q <= rom_data;
    end
  end

  assign rvalid = tag_q[DEPTH-1];
  assign rdata  = (|tag_q[DEPTH-1]) ? rom_data : rdata_q;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) busy = busy | (|tag_q[k]);
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter with a 2-cycle ROM model
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [3:0]  req = '0;
  logic [67:0] addr = '0;
  logic [3:0]  gnt, rvalid;
  logic [11:0] rdata, rom_data;
  logic        rom_en, busy;
  logic [16:0] rom_addr;

  rom_arbiter #(.N_REQ(4), .AW(17), .DW(12), .ROM_LAT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .addr(addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [11:0] rom_f(input logic [16:0] a);
    return a[11:0] ^ {a[16:12], a[6:0]};
  endfunction

  logic [11:0] r1 = '0, r2 = '0;
  always @(posedge clk) begin
    r1 <= rom_f(rom_addr);
    r2 <= r1;
  end
  assign rom_data = r2;

  int n_vec = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct { logic [3:0] oh; logic [11:0] data; int due; } sb_t;
  sb_t q[$];
  logic        exp_rom_en = 1'b0;
  logic [16:0] exp_rom_addr = '0;
  logic [11:0] exp_rdata = '0;

  // Scoreboard: a grant pushes the expected return, rvalid pops it.
  always @(negedge clk) begin
    sb_t it;
    if (rst) begin
      q.delete();
      exp_rom_en   = 1'b0;
      exp_rom_addr = '0;
      exp_rdata    = '0;
    end else begin
      check("rom_en", rom_en, exp_rom_en);
      check("rom_addr", rom_addr, exp_rom_addr);
      check("busy", busy, q.size() != 0);
      if (rvalid != 0) begin
        if (q.size() == 0) check("rvalid_unexpected", rvalid, 0);
        else begin
          it = q.pop_front();
          check("rvalid_tag", rvalid, it.oh);
          check("rdata", rdata, it.data);
          check("rvalid_latency", cycle, it.due);
          exp_rdata = it.data;
        end
      end else begin
        check("rdata_hold", rdata, exp_rdata);
        if (q.size() != 0 && q[0].due <= cycle) begin
          check("rvalid_missing", 0, q[0].oh);
          it = q.pop_front();
        end
      end
      exp_rom_en = (gnt != 0);
      if (gnt != 0) begin
        check("gnt_onehot", $onehot(gnt), 1);
        for (int i = 0; i < 4; i++)
          if (gnt[i]) begin
            exp_rom_addr = addr[i*17 +: 17];
            q.push_back('{gnt, rom_f(addr[i*17 +: 17]), cycle + 3});
          end
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic e);
    @(posedge clk);
    #1;
    req = r;
    en  = e;
    for (int i = 0; i < 4; i++) addr[i*17 +: 17] = 17'($urandom);
  endtask

  task automatic step(input string name, input logic [3:0] r, input logic e, input logic [3:0] exp);
    drive(r, e);
    @(negedge clk);
    check(name, gnt, exp);
  endtask

  task automatic reset_seq(input logic [3:0] r, input logic e);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'hF;
    en  = 1'b1;
    @(negedge clk);
    check("gnt_in_reset", gnt, 0);
    drive(r, e);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rom_en", rom_en, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_rdata", rdata, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_busy", busy, 0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 12) begin
      drive(4'b0000, 1'b1);
      @(negedge clk);
      k++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  typedef struct { logic [3:0] req; logic en; logic [3:0] gnt; } vec_t;
  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0011, 1'b1, 4'b0001};
    tbl[1]  = '{4'b0011, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1010, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1010, 1'b1, 4'b1000};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[9]  = '{4'b0110, 1'b1, 4'b0010};
    tbl[10] = '{4'b0110, 1'b1, 4'b0100};
    tbl[11] = '{4'b1001, 1'b1, 4'b1000};
    tbl[12] = '{4'b1001, 1'b1, 4'b0001};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    reset_seq(4'b0000, 1'b1);

    // Single read from the moon unit at 0x123.
    drive(4'b0100, 1'b1);
    addr[REQ_MOON*17 +: 17] = 17'h00123;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0100);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    check("single_rom_addr", rom_addr, 17'h00123);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    check("single_rvalid", rvalid, 4'b0100);
    check("single_rdata", rdata, rom_f(17'h00123));

    // Pointer is now 3: first rows exercise the wrap to requester 0.
    for (int i = 0; i < 14; i++) step($sformatf("tbl_gnt[%0d]", i), tbl[i].req, tbl[i].en, tbl[i].gnt);
    drain();

    // Full contention from reset.
    reset_seq(4'b1111, 1'b1);
    check("cont_gnt0", gnt, 4'b0001);
    step("cont_gnt1", 4'b1111, 1'b1, 4'b0010);
    step("cont_gnt2", 4'b1111, 1'b1, 4'b0100);
    step("cont_gnt3", 4'b1111, 1'b1, 4'b1000);
    step("cont_gnt4", 4'b1111, 1'b1, 4'b0001);
    drain();

    // En gating with a read already in flight.
    reset_seq(4'b0001, 1'b1);
    check("en_pre_gnt", gnt, 4'b0001);
    for (int i = 0; i < 5; i++) step("en_low_gnt", 4'b0001, 1'b0, 4'b0000);
    step("en_rise_gnt", 4'b0001, 1'b1, 4'b0001);
    drain();

    // Withdrawn request from requester 1.
    reset_seq(4'b0011, 1'b1);
    check("wd_gnt0", gnt, 4'b0001);
    step("wd_dropped", 4'b0000, 1'b1, 4'b0000);
    step("wd_ptr1", 4'b0011, 1'b1, 4'b0010);
    drain();

    // Reset while two reads are in flight.
    reset_seq(4'b0001, 1'b1);
    check("mf_gnt_t", gnt, 4'b0001);
    step("mf_gnt_t1", 4'b0010, 1'b1, 4'b0010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("mf_gnt_rst", gnt, 0);
    drive(4'b0000, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mf_rvalid", rvalid, 0);
      check("mf_busy", busy, 0);
      drive(4'b0000, 1'b1);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
